// File: rtl/fpu_pkg.sv
// fpu_pkg: shared fpu operation codes, arbiter states and constants
package fpu_pkg;
  typedef enum logic [3:0] {
    add_op, sub_op, mul_op, div_op, sqrt_op, min_op, max_op, cmp_op
  } Operation_t;
  typedef enum logic [2:0] {idle, grant, issue, wait_result, drain, deliver} state_t;
  localparam logic [63:0] nan_bits = '1;
endpackage

// File: rtl/fpu_arbiter_rr_select.sv
// rr_select: combinational round-robin picker, first set req bit after last
module rr_select #(
  parameter int n = 4
) (
  input  logic [n-1:0]         req,
  input  logic [$clog2(n)-1:0] last,
  output logic [n-1:0]         onehot,
  output logic [$clog2(n)-1:0] index,
  output logic                 valid
);
  localparam int iw = $clog2(n);
  localparam logic [iw-1:0] top = iw'(n - 1);
  logic [iw-1:0] k;
  always_comb begin
    k = last;
    index = '0;
    valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      k = k == top ? '0 : k + 1'b1;
      if (!valid && req[k]) begin
        valid = 1'b1;
        index = k;
      end
    end
    onehot = valid ? {{(n-1){1'b0}}, 1'b1} << index : '0;
  end
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one non-pipelined fpu between several clients
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int bitness = 32,
  parameter int requesters = 4,
  parameter int timeout = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [requesters-1:0]           req_rdy,
  output logic [requesters-1:0]           req_ack,
  input  logic [requesters*bitness-1:0]   req_data_a,
  input  logic [requesters*bitness-1:0]   req_data_b,
  input  logic [requesters*4-1:0]         req_operation,
  output logic [requesters-1:0]           rsp_rdy,
  input  logic [requesters-1:0]           rsp_ack,
  output logic [bitness-1:0]              rsp_result,
  output logic                            rsp_error,
  output logic                            fpu_input_rdy,
  input  logic                            fpu_input_ack,
  input  logic                            fpu_output_rdy,
  output logic                            fpu_output_ack,
  output logic [bitness-1:0]              fpu_data_a,
  output logic [bitness-1:0]              fpu_data_b,
  output logic [3:0]                      fpu_operation,
  input  logic [bitness-1:0]              fpu_result
);
  localparam int iw = $clog2(requesters);
  localparam int ww = $clog2(timeout + 1);
  localparam logic [requesters-1:0] one = requesters'(1);
  localparam logic [ww-1:0] wd_last = ww'(timeout - 1);
  localparam logic [ww-1:0] wd_max = ww'(timeout);
  state_t state, next;
  logic [iw-1:0] last, owner, sel_index;
  logic [requesters-1:0] sel_onehot;
  logic sel_valid, busy, expire, abort;
  logic [ww-1:0] wd;
  logic [bitness-1:0] a_arr [requesters];
  logic [bitness-1:0] b_arr [requesters];
  logic [3:0] op_arr [requesters];
  genvar g;
  for (g = 0; g < requesters; g++) begin : g_split
    assign a_arr[g] = req_data_a[g*bitness +: bitness];
    assign b_arr[g] = req_data_b[g*bitness +: bitness];
    assign op_arr[g] = req_operation[g*4 +: 4];
  end
  rr_select #(.n(requesters)) u_sel (
    .req(req_rdy),
    .last,
    .onehot(sel_onehot),
    .index(sel_index),
    .valid(sel_valid)
  );
  assign busy = state inside {issue, wait_result, drain};
  assign expire = busy && wd == wd_last;
  // a handshake completing on the last watchdog cycle still wins over the abort
  assign abort = expire && (state == issue ? !fpu_input_ack :
                            state == wait_result ? !fpu_output_rdy : fpu_output_rdy);
  always_ff @(posedge clock) state <= reset ? idle : next;
  always_comb begin
    next = state;
    case (state)
      idle:        next = |req_rdy ? grant : idle;
      grant:       next = sel_valid ? issue : idle;
      issue:       next = abort ? deliver : fpu_input_ack ? wait_result : issue;
      wait_result: next = abort ? deliver : fpu_output_rdy ? drain : wait_result;
      drain:       next = abort || !fpu_output_rdy ? deliver : drain;
      deliver:     next = rsp_ack[owner] ? idle : deliver;
      default:     next = idle;
    endcase
  end
  always_comb begin
    req_ack = state == grant ? sel_onehot : '0;
    rsp_rdy = state == deliver ? one << owner : '0;
    fpu_input_rdy = state == issue;
    fpu_output_ack = state == drain;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= iw'(requesters - 1);
      owner <= '0;
      wd <= '0;
      fpu_data_a <= '0;
      fpu_data_b <= '0;
      fpu_operation <= '0;
      rsp_result <= '0;
      rsp_error <= 1'b0;
    end else begin
      wd <= next != state || !busy ? '0 : wd == wd_max ? wd : wd + 1'b1;
      if (state == grant && sel_valid) begin
        owner <= sel_index;
        fpu_data_a <= a_arr[sel_index];
        fpu_data_b <= b_arr[sel_index];
        fpu_operation <= op_arr[sel_index];
        rsp_error <= 1'b0;
      end
      if (state == wait_result && fpu_output_rdy) rsp_result <= fpu_result;
      if (abort) begin
        rsp_result <= nan_bits[bitness-1:0];
        rsp_error <= 1'b1;
      end
      if (state == deliver && rsp_ack[owner]) last <= owner;
    end
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed checks of grant order, latencies, watchdog and reset
module tb_fpu_arbiter;
  import fpu_pkg::*;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;
  logic [3:0] req_rdy, req_ack, rsp_rdy, rsp_ack;
  logic [127:0] req_data_a, req_data_b;
  logic [15:0] req_operation;
  logic [31:0] rsp_result;
  logic rsp_error;
  logic fpu_input_rdy, fpu_output_ack;
  logic fpu_input_ack = 1'b0, fpu_output_rdy = 1'b0;
  logic [31:0] fpu_data_a, fpu_data_b;
  logic [31:0] fpu_result = '0;
  logic [3:0] fpu_operation;
  logic fpu_hang = 1'b0, fpu_hold = 1'b0, pend = 1'b0;
  logic [31:0] res_q = '0;
  int n_checks = 0, n_fail = 0;
  logic [31:0] op_a [4] = '{32'h3F800000, 32'h00000100, 32'h11111111, 32'hFFFFFFFF};
  logic [31:0] op_b [4] = '{32'h40000000, 32'h00000020, 32'h22222222, 32'h00000002};
  logic [3:0] op_c [4] = '{add_op, sub_op, mul_op, 4'hF};
  logic [31:0] exp_r [4] = '{32'h7F800000, 32'h00000121, 32'h33333335, 32'h00000010};

  fpu_arbiter #(.bitness(32), .requesters(4), .timeout(15)) dut (
    .clock(clock), .reset(reset),
    .req_rdy(req_rdy), .req_ack(req_ack),
    .req_data_a(req_data_a), .req_data_b(req_data_b), .req_operation(req_operation),
    .rsp_rdy(rsp_rdy), .rsp_ack(rsp_ack), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
    .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack),
    .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result)
  );

  // toy fpu: result = a + b + op, returned two cycles after the input handshake
  always @(negedge clock) begin
    if (reset) begin
      fpu_input_ack = 1'b0;
      fpu_output_rdy = 1'b0;
      pend = 1'b0;
    end else begin
      if (fpu_output_rdy && fpu_output_ack && !fpu_hold) fpu_output_rdy = 1'b0;
      else if (pend && !fpu_hang) begin
        fpu_output_rdy = 1'b1;
        fpu_result = res_q;
        pend = 1'b0;
      end
      if (fpu_input_ack) begin
        pend = !fpu_hang;
        res_q = fpu_data_a + fpu_data_b + 32'(fpu_operation);
      end
      fpu_input_ack = fpu_input_rdy;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int k, input logic drop, input int hold);
    int n;
    n = 0;
    while (req_ack == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check("grant", req_ack, 4'b1 << k);
    check("grant latency", n, 1);
    tick();
    check("issue rdy", fpu_input_rdy, 1);
    check("issue operands", {fpu_data_a, fpu_data_b, fpu_operation}, {op_a[k], op_b[k], op_c[k]});
    if (drop) req_rdy[k] = 1'b0;
    n = 0;
    while (rsp_rdy == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    check("return latency", n, 4);
    check("rsp rdy", rsp_rdy, 4'b1 << k);
    check("rsp result", {rsp_error, rsp_result}, {1'b0, exp_r[k]});
    for (int i = 0; i < hold; i++) begin
      rsp_ack = ~(4'b1 << k);
      tick();
      check("hold", {rsp_rdy, req_ack, rsp_result}, {4'b1 << k, 4'b0, exp_r[k]});
    end
    rsp_ack = 4'b1 << k;
    tick();
    rsp_ack = 4'b0;
    check("rsp done", rsp_rdy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n, cnt;
    reset = 1'b1;
    req_rdy = 4'b0;
    rsp_ack = 4'b0;
    for (int i = 0; i < 4; i++) begin
      req_data_a[i*32 +: 32] = op_a[i];
      req_data_b[i*32 +: 32] = op_b[i];
      req_operation[i*4 +: 4] = op_c[i];
    end
    tick();
    tick();
    check("reset ctrl", {req_ack, rsp_rdy, rsp_error, fpu_input_rdy, fpu_output_ack}, 0);
    check("reset data", {rsp_result, fpu_data_a, fpu_data_b, fpu_operation}, 0);
    reset = 1'b0;
    tick();
    // single client 0
    req_rdy = 4'b0001;
    serve(0, 1'b1, 0);
    // all four continuously, starting from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_rdy = 4'b1111;
    serve(0, 1'b0, 0);
    serve(1, 1'b0, 0);
    serve(2, 1'b0, 0);
    serve(3, 1'b0, 0);
    serve(0, 1'b0, 0);
    req_rdy = 4'b0;
    // after client 2, clients 1 and 3 together: 3 first
    req_rdy = 4'b0100;
    serve(2, 1'b1, 0);
    req_rdy = 4'b1010;
    serve(3, 1'b1, 0);
    serve(1, 1'b1, 0);
    // wrong-client acks ignored while client 0 waits
    req_rdy = 4'b0101;
    serve(2, 1'b1, 10);
    serve(0, 1'b1, 0);
    // watchdog in wait_result
    fpu_hang = 1'b1;
    req_rdy = 4'b0001;
    n = 0;
    while (req_ack == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check("to grant", req_ack, 4'b0001);
    tick();
    req_rdy = 4'b0;
    check("to issue", fpu_input_rdy, 1);
    n = 0;
    cnt = 0;
    while (rsp_rdy == 4'b0 && n < 40) begin
      tick();
      n++;
      if (rsp_rdy == 4'b0 && !fpu_input_rdy && !fpu_output_ack) cnt++;
    end
    check("wait cycles", cnt, 15);
    check("to rsp", rsp_rdy, 4'b0001);
    check("to error", {rsp_error, rsp_result}, {1'b1, 32'hFFFFFFFF});
    rsp_ack = 4'b0001;
    tick();
    rsp_ack = 4'b0;
    fpu_hang = 1'b0;
    // reset while in drain
    fpu_hold = 1'b1;
    req_rdy = 4'b0001;
    n = 0;
    while (!fpu_output_ack && n < 20) begin
      tick();
      n++;
    end
    check("drain reached", fpu_output_ack, 1);
    req_rdy = 4'b0;
    tick();
    check("drain held", fpu_output_ack, 1);
    reset = 1'b1;
    tick();
    check("mid reset ctrl", {req_ack, rsp_rdy, rsp_error, fpu_input_rdy, fpu_output_ack}, 0);
    check("mid reset data", {rsp_result, fpu_data_a, fpu_data_b, fpu_operation}, 0);
    reset = 1'b0;
    fpu_hold = 1'b0;
    tick();
    check("no stale rsp", {rsp_rdy, req_ack, fpu_input_rdy, fpu_output_ack}, 0);
    req_rdy = 4'b0001;
    serve(0, 1'b1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
